// File: rtl/second_tick_pkg.sv
// Shared definitions for the second-tick event detector array:
// detect-mode encodings and the raw per-channel detect rule.
package second_tick_pkg;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    // Unqualified detect for one channel, before inhibit, hold-off and arming.
    function automatic logic raw_detect(input logic [1:0] mode, input logic cur, input logic prev);
        logic r;
        case (mode)
            MODE_LEVEL: r = cur;
            MODE_RISE:  r = cur & ~prev;
            MODE_FALL:  r = ~cur & prev;
            default:    r = cur ^ prev;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/second_tick_chan.sv
// One detector channel: input history, hold-off window, sticky pending flag
// and saturating event counter.
module second_tick_chan
    import second_tick_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0,
    input  logic             in1,
    input  logic [1:0]       mode,
    input  logic             armed,
    input  logic             clr,
    output logic             out,
    output logic             pending,
    output logic             pending_next,
    output logic [CNT_W-1:0] counter
);

    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic             in0_q;
    logic [HW-1:0]    hcnt;
    logic             accept;
    logic [CNT_W-1:0] counter_next;

    // A coincident clear and event leave the channel with exactly one fresh event.
    always_comb begin
        accept = raw_detect(mode, in0, in0_q) & ~in1 & (hcnt == '0)
                 & (armed | (mode == MODE_LEVEL));
        pending_next = accept | (pending & ~clr);
        counter_next = counter;
        if (clr) begin
            counter_next = '0;
        end
        if (accept && (counter_next != '1)) begin
            counter_next = counter_next + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in0_q   <= 1'b0;
            hcnt    <= '0;
            out     <= 1'b0;
            pending <= 1'b0;
            counter <= '0;
        end else begin
            in0_q   <= in0;
            out     <= accept;
            pending <= pending_next;
            counter <= counter_next;
            if (HOLDOFF > 0) begin
                if (accept) begin
                    hcnt <= HW'(HOLDOFF);
                end else if (hcnt != '0) begin
                    hcnt <= hcnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/second_tick_array.sv
// WIDTH-channel registered "in0 AND NOT in1" event detector with selectable
// edge mode, hold-off, sticky pending flags and a muxed counter readout.
module second_tick_array
    import second_tick_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 0,
    parameter int SEL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] clr,
    input  logic [SEL_W-1:0] count_sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pending,
    output logic             any_pending,
    output logic [CNT_W-1:0] count
);

    logic             armed;
    logic [WIDTH-1:0] pending_next;
    logic [CNT_W-1:0] counters [WIDTH];
    logic [CNT_W-1:0] sel_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        second_tick_chan #(
            .CNT_W  (CNT_W),
            .HOLDOFF(HOLDOFF)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .in0         (in0[i]),
            .in1         (in1[i]),
            .mode        (mode),
            .armed       (armed),
            .clr         (clr[i]),
            .out         (out[i]),
            .pending     (pending[i]),
            .pending_next(pending_next[i]),
            .counter     (counters[i])
        );
    end

    // Out-of-range selects match no channel and read back as zero.
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (32'(count_sel) == i) begin
                sel_count = counters[i];
            end
        end
    end

    // armed stays low for the first cycle after reset so inputs already high don't look like edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b0;
            count       <= '0;
            any_pending <= 1'b0;
        end else begin
            armed       <= 1'b1;
            count       <= sel_count;
            any_pending <= |pending_next;
        end
    end

endmodule

// File: tb/tb_second_tick_array.sv
// Randomized and directed bench for second_tick_array: two instances (no hold-off with
// a 2-bit counter, and hold-off 3 with an 8-bit counter) checked against an event-time model.
module tb_second_tick_array;

    localparam int WIDTH = 8;
    localparam int SEL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in0, in1, clr;
    logic [1:0]       mode;
    logic [SEL_W-1:0] count_sel;
    logic [WIDTH-1:0] out0, pend0, out1, pend1;
    logic             any0, any1;
    logic [1:0]       cnt0;
    logic [7:0]       cnt1;

    int checks = 0;
    int errors = 0;

    // Model state: time of last accepted event per channel, plain integer counts.
    int         holdCfg [2] = '{0, 3};
    int         cntMax  [2] = '{3, 255};
    bit         mPrev   [WIDTH];
    bit         mArmed;
    int         cyc;
    int         lastAcc [2][WIDTH];
    int         eCnt    [2][WIDTH];
    logic [7:0] eOut    [2];
    logic [7:0] ePend   [2];
    logic       eAny    [2];
    int         eCount  [2];

    always #5 clk = ~clk;

    second_tick_array #(.WIDTH(WIDTH), .CNT_W(2), .HOLDOFF(0), .SEL_W(SEL_W)) dut0 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .mode(mode), .clr(clr),
        .count_sel(count_sel), .out(out0), .pending(pend0), .any_pending(any0), .count(cnt0)
    );

    second_tick_array #(.WIDTH(WIDTH), .CNT_W(8), .HOLDOFF(3), .SEL_W(SEL_W)) dut1 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .mode(mode), .clr(clr),
        .count_sel(count_sel), .out(out1), .pending(pend1), .any_pending(any1), .count(cnt1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelEdge();
        int sel;
        bit cur, prv, raw, ok;
        sel = int'(count_sel);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                eOut[k] = '0; ePend[k] = '0; eAny[k] = 1'b0; eCount[k] = 0;
                for (int i = 0; i < WIDTH; i++) begin
                    eCnt[k][i] = 0;
                    lastAcc[k][i] = -100;
                end
            end else begin
                eCount[k] = (sel < WIDTH) ? eCnt[k][sel] : 0;
                for (int i = 0; i < WIDTH; i++) begin
                    cur = in0[i];
                    prv = mPrev[i];
                    case (mode)
                        2'b00:   raw = cur;
                        2'b01:   raw = cur && !prv;
                        2'b10:   raw = !cur && prv;
                        default: raw = (cur != prv);
                    endcase
                    ok = raw && !in1[i] && ((cyc - lastAcc[k][i]) > holdCfg[k])
                         && (mArmed || mode == 2'b00);
                    eOut[k][i] = ok;
                    if (ok) lastAcc[k][i] = cyc;
                    if (clr[i]) begin
                        ePend[k][i] = 1'b0;
                        eCnt[k][i] = 0;
                    end
                    if (ok) begin
                        ePend[k][i] = 1'b1;
                        if (eCnt[k][i] < cntMax[k]) eCnt[k][i]++;
                    end
                end
                eAny[k] = |ePend[k];
            end
        end
        for (int i = 0; i < WIDTH; i++) mPrev[i] = rst ? 1'b0 : in0[i];
        mArmed = !rst;
        cyc++;
    endtask

    // One clock: model advances with the inputs seen at the edge, outputs checked 1ns later.
    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("d0_out", out0, eOut[0]);
        checkOutput("d0_pending", pend0, ePend[0]);
        checkOutput("d0_any", any0, eAny[0]);
        checkOutput("d0_count", cnt0, eCount[0]);
        checkOutput("d1_out", out1, eOut[1]);
        checkOutput("d1_pending", pend1, ePend[1]);
        checkOutput("d1_any", any1, eAny[1]);
        checkOutput("d1_count", cnt1, eCount[1]);
    endtask

    initial begin
        logic [9:0] pulseMask;
        cyc = 0;
        mArmed = 1'b0;
        for (int i = 0; i < WIDTH; i++) mPrev[i] = 1'b0;
        rst = 1'b1; in0 = 8'hFF; in1 = '0; clr = '0; mode = 2'b01; count_sel = '0;
        #1;
        applyStimulus();
        applyStimulus();
        checkOutput("tp1_reset_out", out0, 0);

        // Input high across reset release must not look like a rising edge.
        rst = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("tp1_no_rise", out0, 0);
        checkOutput("tp1_no_pending", pend0, 0);
        in0 = 8'h00;
        applyStimulus();
        in0 = 8'h01;
        applyStimulus();
        checkOutput("tp1_edge_out", out0, 8'h01);
        checkOutput("tp1_edge_pending", pend0, 8'h01);
        applyStimulus();
        checkOutput("tp1_single_pulse", out0, 0);
        checkOutput("tp1_count", cnt0, 1);

        mode = 2'b00; in0 = 8'h05; in1 = 8'h03;
        applyStimulus();
        checkOutput("tp2_and_not_d0", out0, 8'h04);
        checkOutput("tp2_and_not_d1", out1, 8'h04);

        rst = 1'b1; in0 = '0; in1 = '0;
        applyStimulus();
        rst = 1'b0; mode = 2'b11; count_sel = 4'd2;
        applyStimulus();
        applyStimulus();
        pulseMask = '0;
        for (int j = 0; j < 10; j++) begin
            in0 = (j % 2 == 0) ? 8'h04 : 8'h00;
            applyStimulus();
            pulseMask[j] = out1[2];
        end
        checkOutput("tp3_holdoff_pulses", pulseMask, 10'b01_0001_0001);
        applyStimulus();
        applyStimulus();
        checkOutput("tp3_holdoff_count", cnt1, 3);

        mode = 2'b01; count_sel = 4'd1; in0 = '0; clr = 8'hFF;
        applyStimulus();
        clr = '0;
        for (int e = 0; e < 5; e++) begin
            in0 = 8'h02;
            applyStimulus();
            in0 = 8'h00;
            applyStimulus();
        end
        applyStimulus();
        checkOutput("tp4_saturate", cnt0, 3);
        in0 = 8'h02; clr = 8'h02;
        applyStimulus();
        checkOutput("tp4_clr_event_pending", pend0[1], 1);
        clr = '0;
        applyStimulus();
        checkOutput("tp4_clr_event_count", cnt0, 1);

        count_sel = 4'd8;
        applyStimulus();
        checkOutput("tp5_sel_oob_d0", cnt0, 0);
        checkOutput("tp5_sel_oob_d1", cnt1, 0);
        in0 = '0; clr = 8'hFF;
        applyStimulus();
        checkOutput("tp5_clear_pending", pend0, 0);
        checkOutput("tp5_clear_any", any0, 0);
        clr = '0;
        for (int s = 0; s < WIDTH; s++) begin
            count_sel = SEL_W'(s);
            applyStimulus();
            applyStimulus();
            checkOutput("tp5_count_zero", cnt1, 0);
        end

        rst = 1'b1;
        applyStimulus();
        rst = 1'b0; mode = 2'b01; in0 = '0; count_sel = '0;
        applyStimulus();
        applyStimulus();
        in0 = 8'hA5;
        applyStimulus();
        checkOutput("tp6_pending_a5", pend0, 8'hA5);
        rst = 1'b1;
        applyStimulus();
        checkOutput("tp6_rst_pending", pend1, 0);
        checkOutput("tp6_rst_any", any1, 0);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            applyStimulus();
            checkOutput("tp6_no_rise_after_rst", out1, 0);
        end

        for (int n = 0; n < 800; n++) begin
            in0 = 8'($urandom);
            in1 = 8'($urandom & $urandom);
            clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            count_sel = SEL_W'($urandom_range(0, 9));
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
